main_memory_ctrl: RTL and testbench

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl.sv | 131 +++++++++++++
 tb/tb_main_memory_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// Main memory behind the L1 cache: a 32x8 array with a fixed read latency.
// A small write-back FIFO absorbs dirty lines, forwards them to reads and drains while idle.
module main_memory_ctrl #(
  parameter int LATENCY  = 3,
  parameter int WB_DEPTH = 2
) (
  input  logic       clock_in,
  input  logic       resetn_in,
  input  logic       req_in,
  input  logic       we_in,
  input  logic [4:0] addr_in,
  input  logic [7:0] data_in,
  output logic       ready_out,
  output logic       valid_out,
  output logic [7:0] q_out,
  output logic       busy_out,
  output logic [1:0] wb_count_out
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ_WAIT = 2'd1;
  localparam logic [1:0] RESPOND   = 2'd2;

  logic [1:0] state;
  logic [2:0] lat_cnt;
  logic [4:0] rd_addr;
  logic [7:0] mem [32];
  logic [4:0] wb_addr [4];
  logic [7:0] wb_data [4];
  logic [1:0] head;
  logic [1:0] tail;
  logic [1:0] wb_count;

  logic       accept;
  logic       push;
  logic       rd_acc;
  logic       drain;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic [2:0] pos;
  logic [1:0] ix;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(WB_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign ready_out    = (state == IDLE) && (wb_count < 2'(WB_DEPTH));
  assign valid_out    = (state == RESPOND);
  assign busy_out     = (state != IDLE) || (wb_count != 2'd0);
  assign wb_count_out = wb_count;

  assign accept = req_in && ready_out;
  assign push   = accept && we_in;
  assign rd_acc = accept && !we_in;
  assign drain  = (state == IDLE) && (wb_count != 2'd0) && !rd_acc;

  // Walk oldest to newest so the last hit left standing is the newest matching entry.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    ix       = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      pos = {1'b0, head} + 3'(i);
      if (pos >= 3'(WB_DEPTH)) pos = pos - 3'(WB_DEPTH);
      ix = pos[1:0];
      if ((2'(i) < wb_count) && (wb_addr[ix] == addr_in)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[ix];
      end
    end
  end

  always_ff @(posedge clock_in or negedge resetn_in) begin
    if (!resetn_in) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      rd_addr  <= '0;
      q_out    <= '0;
      head     <= '0;
      tail     <= '0;
      wb_count <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        wb_addr[i] <= '0;
        wb_data[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (rd_acc) begin
            if (fwd_hit) begin
              q_out <= fwd_data;
              state <= RESPOND;
            end else begin
              rd_addr <= addr_in;
              lat_cnt <= 3'(LATENCY - 1);
              state   <= READ_WAIT;
            end
          end
        end
        // Leave as the count reaches zero so the L1 samples valid on edge LATENCY after acceptance.
        READ_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            q_out <= mem[rd_addr];
            state <= RESPOND;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) begin
        wb_addr[tail] <= addr_in;
        wb_data[tail] <= data_in;
        tail          <= next_ptr(tail);
      end
      if (drain) begin
        mem[wb_addr[head]] <= wb_data[head];
        head               <= next_ptr(head);
      end
      case ({push, drain})
        2'b10:   wb_count <= wb_count + 2'd1;
        2'b01:   wb_count <= wb_count - 2'd1;
        default: wb_count <= wb_count;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: inputs change and outputs are sampled on the falling edge.
// A read's latency is the index of the first falling edge after acceptance that shows valid_out.
module tb_main_memory_ctrl;

  logic       clock_in  = 1'b0;
  logic       resetn_in = 1'b0;
  logic       req_in    = 1'b0;
  logic       we_in     = 1'b0;
  logic [4:0] addr_in   = '0;
  logic [7:0] data_in   = '0;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] q_out;
  logic       busy_out;
  logic [1:0] wb_count_out;

  int errorCount = 0;
  int checkCount = 0;

  main_memory_ctrl #(.LATENCY(3), .WB_DEPTH(2)) dut (
    .clock_in    (clock_in),
    .resetn_in   (resetn_in),
    .req_in      (req_in),
    .we_in       (we_in),
    .addr_in     (addr_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .q_out       (q_out),
    .busy_out    (busy_out),
    .wb_count_out(wb_count_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [4:0] addr, input logic [7:0] data);
    req_in  = req;
    we_in   = we;
    addr_in = addr;
    data_in = data;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic writeLine(input logic [4:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
    @(negedge clock_in);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
  endtask

  task automatic readLine(input logic [4:0] addr, input string tag, input int expLat, input logic [7:0] expData);
    int lat;
    applyStimulus(1'b1, 1'b0, addr, 8'd0);
    @(negedge clock_in);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    lat = 1;
    while (!valid_out && lat < 20) begin
      @(negedge clock_in);
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_q"}, q_out, expData);
    @(negedge clock_in);
    checkOutput({tag, "_vdrop"}, valid_out, 1'b0);
  endtask

  initial begin
    bit sawValid;
    repeat (2) @(negedge clock_in);
    checkOutput("rst_ready", ready_out, 1'b1);
    checkOutput("rst_valid", valid_out, 1'b0);
    checkOutput("rst_q", q_out, 8'h00);
    checkOutput("rst_busy", busy_out, 1'b0);
    checkOutput("rst_cnt", wb_count_out, 2'd0);

    // Request presented together with reset release must be taken on the very next edge
    resetn_in = 1'b1;
    readLine(5'b10100, "rd_cold", 3, 8'h00);
    checkOutput("cold_ready", ready_out, 1'b1);
    checkOutput("cold_busy", busy_out, 1'b0);

    writeLine(5'b10110, 8'hA5);
    checkOutput("wr_cnt", wb_count_out, 2'd1);
    checkOutput("wr_busy", busy_out, 1'b1);
    checkOutput("wr_ready", ready_out, 1'b1);
    readLine(5'b10110, "rd_fwd", 1, 8'hA5);
    checkOutput("fwd_nodrain", wb_count_out, 2'd1);
    idleCycles(1);
    checkOutput("fwd_drained", wb_count_out, 2'd0);
    checkOutput("fwd_idle_busy", busy_out, 1'b0);
    checkOutput("q_hold", q_out, 8'hA5);
    readLine(5'b10110, "rd_after_drain", 3, 8'hA5);

    // Back-to-back writes: the second edge pushes and drains, so occupancy stays at one
    applyStimulus(1'b1, 1'b1, 5'd1, 8'h11);
    @(negedge clock_in);
    checkOutput("b2b_cnt1", wb_count_out, 2'd1);
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h22);
    @(negedge clock_in);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    checkOutput("b2b_cnt2", wb_count_out, 2'd1);
    checkOutput("b2b_ready", ready_out, 1'b1);
    idleCycles(1);
    checkOutput("b2b_empty", wb_count_out, 2'd0);
    readLine(5'd1, "rd_a1", 3, 8'h11);
    readLine(5'd2, "rd_a2", 3, 8'h22);

    applyStimulus(1'b1, 1'b1, 5'd3, 8'h33);
    @(negedge clock_in);
    applyStimulus(1'b1, 1'b1, 5'd3, 8'h44);
    @(negedge clock_in);
    idleCycles(1);
    checkOutput("lww_empty", wb_count_out, 2'd0);
    readLine(5'd3, "rd_lww", 3, 8'h44);
    writeLine(5'd3, 8'h55);
    readLine(5'd3, "rd_fwd_new", 1, 8'h55);
    idleCycles(1);

    applyStimulus(1'b1, 1'b1, 5'd7, 8'h77);
    @(negedge clock_in);
    applyStimulus(1'b1, 1'b1, 5'd8, 8'h88);
    @(negedge clock_in);
    checkOutput("dp_cnt", wb_count_out, 2'd1);
    applyStimulus(1'b1, 1'b0, 5'd9, 8'h00);
    @(negedge clock_in);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    checkOutput("rw1_ready", ready_out, 1'b0);
    checkOutput("rw1_cnt", wb_count_out, 2'd1);
    checkOutput("rw1_valid", valid_out, 1'b0);
    @(negedge clock_in);
    checkOutput("rw2_ready", ready_out, 1'b0);
    checkOutput("rw2_cnt", wb_count_out, 2'd1);
    checkOutput("rw2_valid", valid_out, 1'b0);
    @(negedge clock_in);
    checkOutput("rw3_valid", valid_out, 1'b1);
    checkOutput("rw3_q", q_out, 8'h00);
    checkOutput("rw3_cnt", wb_count_out, 2'd1);
    @(negedge clock_in);
    checkOutput("rw4_cnt", wb_count_out, 2'd1);
    idleCycles(1);
    checkOutput("rw5_cnt", wb_count_out, 2'd0);
    readLine(5'd8, "rd_a8", 3, 8'h88);
    readLine(5'd7, "rd_a7", 3, 8'h77);

    // Reset during a read with a write still buffered
    writeLine(5'd12, 8'h5A);
    applyStimulus(1'b1, 1'b0, 5'd1, 8'h00);
    @(negedge clock_in);
    applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
    checkOutput("mr_cnt", wb_count_out, 2'd1);
    @(negedge clock_in);
    resetn_in = 1'b0;
    #1;
    checkOutput("mr_valid", valid_out, 1'b0);
    checkOutput("mr_ready", ready_out, 1'b1);
    checkOutput("mr_busy", busy_out, 1'b0);
    checkOutput("mr_cnt0", wb_count_out, 2'd0);
    checkOutput("mr_q", q_out, 8'h00);
    @(negedge clock_in);
    resetn_in = 1'b1;
    sawValid = 1'b0;
    repeat (5) begin
      @(negedge clock_in);
      if (valid_out) sawValid = 1'b1;
    end
    checkOutput("mr_novalid", sawValid, 1'b0);
    readLine(5'd12, "rd_discarded", 3, 8'h00);
    readLine(5'd1, "rd_cleared", 3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
